// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-port instruction memory arbiter, fetch priority with L starvation guard
// Optional IMEM_ARB_STATS_EN adds conflict_cnt / forced_cnt statistics outputs.
module imem_arbiter #(
    parameter int ADDR_BIT_WIDTH = 11,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      f_req,
    input  logic [ADDR_BIT_WIDTH-1:0] f_addr,
    output logic                      f_gnt,
    output logic                      f_rvalid,
    output logic [DATA_BIT_WIDTH-1:0] f_rdata,
    input  logic                      f_rready,
    input  logic                      l_req,
    input  logic [ADDR_BIT_WIDTH-1:0] l_addr,
    output logic                      l_gnt,
    output logic                      l_rvalid,
    output logic [DATA_BIT_WIDTH-1:0] l_rdata,
    input  logic                      l_rready,
    output logic [ADDR_BIT_WIDTH-1:0] mem_addr,
    input  logic [DATA_BIT_WIDTH-1:0] mem_data
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [15:0]               conflict_cnt,
    output logic [15:0]               forced_cnt
`endif
);

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic                      r_f_rvalid;
    logic [DATA_BIT_WIDTH-1:0] r_f_rdata;
    logic                      r_l_rvalid;
    logic [DATA_BIT_WIDTH-1:0] r_l_rdata;
    logic [3:0]                r_starve;

    logic w_f_elig;
    logic w_l_elig;
    logic w_force_l;
    logic w_f_gnt;
    logic w_l_gnt;

    // A full buffer that drains this cycle can accept a new word on the same edge.
    assign w_f_elig  = f_req & (~r_f_rvalid | f_rready);
    assign w_l_elig  = l_req & (~r_l_rvalid | l_rready);
    assign w_force_l = (r_starve >= LP_LIMIT) & w_l_elig;
    assign w_f_gnt   = ~w_force_l & w_f_elig;
    assign w_l_gnt   = w_force_l | (~w_f_elig & w_l_elig);

    assign f_gnt    = w_f_gnt;
    assign l_gnt    = w_l_gnt;
    assign mem_addr = w_l_gnt ? l_addr : f_addr;
    assign f_rvalid = r_f_rvalid;
    assign f_rdata  = r_f_rdata;
    assign l_rvalid = r_l_rvalid;
    assign l_rdata  = r_l_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f_rvalid <= 1'b0;
            r_f_rdata  <= '0;
        end else if (w_f_gnt) begin
            r_f_rvalid <= 1'b1;
            r_f_rdata  <= mem_data;
        end else if (r_f_rvalid && f_rready) begin
            r_f_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_l_rvalid <= 1'b0;
            r_l_rdata  <= '0;
        end else if (w_l_gnt) begin
            r_l_rvalid <= 1'b1;
            r_l_rdata  <= mem_data;
        end else if (r_l_rvalid && l_rready) begin
            r_l_rvalid <= 1'b0;
        end
    end

    // Back-pressure on L's own buffer holds the count rather than advancing it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= 4'd0;
        end else if (w_l_gnt || !l_req) begin
            r_starve <= 4'd0;
        end else if (w_l_elig && r_starve != 4'd15) begin
            r_starve <= r_starve + 4'd1;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] r_conflict_cnt;
    logic [15:0] r_forced_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_conflict_cnt <= 16'd0;
            r_forced_cnt   <= 16'd0;
        end else begin
            if (w_f_elig && w_l_elig && r_conflict_cnt != 16'hFFFF)
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            if (w_force_l && r_forced_cnt != 16'hFFFF)
                r_forced_cnt <= r_forced_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign forced_cnt   = r_forced_cnt;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - self-checking bench for imem_arbiter with a cycle-level reference model
module tb_imem_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          f_rready = 1'b0;
    logic          l_req = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic          l_gnt;
    logic          l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          l_rready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
`ifdef IMEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt;
    logic [15:0]   forced_cnt;
`endif

    logic [DW-1:0] tb_mem [0:(1<<AW)-1];
    assign mem_data = tb_mem[mem_addr];

    int n_cmp = 0;
    int n_err = 0;

    imem_arbiter #(
        .ADDR_BIT_WIDTH(AW),
        .DATA_BIT_WIDTH(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .f_req(f_req),
        .f_addr(f_addr),
        .f_gnt(f_gnt),
        .f_rvalid(f_rvalid),
        .f_rdata(f_rdata),
        .f_rready(f_rready),
        .l_req(l_req),
        .l_addr(l_addr),
        .l_gnt(l_gnt),
        .l_rvalid(l_rvalid),
        .l_rdata(l_rdata),
        .l_rready(l_rready),
        .mem_addr(mem_addr),
        .mem_data(mem_data)
`ifdef IMEM_ARB_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .forced_cnt(forced_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each port is a one-slot mailbox; m_wait counts cycles L sat eligible but denied.
    logic          m_fv = 1'b0;
    logic [DW-1:0] m_fd = '0;
    logic          m_lv = 1'b0;
    logic [DW-1:0] m_ld = '0;
    int            m_wait = 0;

    always @(negedge clk) begin
        bit fe, le, frc, eg_f, eg_l;
        if (!reset_n) begin
            m_fv = 1'b0; m_fd = '0; m_lv = 1'b0; m_ld = '0; m_wait = 0;
        end
        fe   = f_req && (!m_fv || f_rready);
        le   = l_req && (!m_lv || l_rready);
        frc  = (m_wait >= LIMIT) && le;
        eg_l = frc || (!fe && le);
        eg_f = !eg_l && fe;
        chk("m_f_gnt",    32'(f_gnt),    32'(eg_f));
        chk("m_l_gnt",    32'(l_gnt),    32'(eg_l));
        chk("m_mem_addr", 32'(mem_addr), 32'(eg_l ? l_addr : f_addr));
        chk("m_f_rvalid", 32'(f_rvalid), 32'(m_fv));
        chk("m_f_rdata",  f_rdata,       m_fd);
        chk("m_l_rvalid", 32'(l_rvalid), 32'(m_lv));
        chk("m_l_rdata",  l_rdata,       m_ld);
        if (reset_n) begin
            if (eg_f) begin m_fv = 1'b1; m_fd = tb_mem[f_addr]; end
            else if (f_rready) m_fv = 1'b0;
            if (eg_l) begin m_lv = 1'b1; m_ld = tb_mem[l_addr]; end
            else if (l_rready) m_lv = 1'b0;
            if (eg_l || !l_req) m_wait = 0;
            else if (le) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
        end
    end

    initial begin
        logic [DW-1:0] d0;
        logic          pf, pl;
        for (int a = 0; a < (1 << AW); a++) tb_mem[a] = (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        tb_mem[16] = 32'hDEADBEEF;

        // Reset state
        #12;
        chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("rst_f_rdata",  f_rdata, 32'd0);
        step();
        reset_n = 1'b1;

        // Single fetch
        step();
        f_req = 1'b1; f_addr = 11'h010; f_rready = 1'b1;
        #1;
        chk("single_f_gnt", 32'(f_gnt), 32'd1);
        chk("single_l_gnt", 32'(l_gnt), 32'd0);
        step();
        f_req = 1'b0;
        #1;
        chk("single_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("single_f_rdata",  f_rdata, 32'hDEADBEEF);
        step();

        // Conflict: grants F,F,F,F,L repeating
        f_req = 1'b1; l_req = 1'b1; f_rready = 1'b1; l_rready = 1'b1;
        f_addr = 11'h100; l_addr = 11'h200;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("conflict_l_gnt",    32'(l_gnt),    32'((i % 5) == 4));
            chk("conflict_mem_addr", 32'(mem_addr), ((i % 5) == 4) ? 32'h200 : 32'h100);
            step();
        end
        l_req = 1'b0;

        // Back-pressure on F
        f_addr = 11'h123;
        step();
        f_rready = 1'b0; f_addr = 11'h124;
        #1;
        d0 = f_rdata;
        chk("bp_first_data", d0, tb_mem[11'h123]);
        for (int i = 0; i < 5; i++) begin
            chk("bp_f_gnt",   32'(f_gnt), 32'd0);
            chk("bp_f_rdata", f_rdata, d0);
            step();
        end
        f_rready = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(f_gnt), 32'd1);
        step();
        f_addr = 11'h125;
        #1;
        chk("bp_new_rvalid", 32'(f_rvalid), 32'd1);
        chk("bp_new_rdata",  f_rdata, tb_mem[11'h124]);
        chk("bp_no_bubble",  32'(f_gnt), 32'd1);
        step();

        // Load buffer full: F wins every cycle, L never forced
        f_req = 1'b0; l_req = 1'b1; l_rready = 1'b0; l_addr = 11'h300;
        step();
        l_addr = 11'h301;
        f_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("lfull_f_gnt", 32'(f_gnt), 32'd1);
            chk("lfull_l_gnt", 32'(l_gnt), 32'd0);
            step();
        end
        l_rready = 1'b1;
        #1;
        chk("lfull_release_l_gnt", 32'(l_gnt), 32'd0);
        step();

        // Reset mid-operation
        f_req = 1'b1; l_req = 1'b1; f_rready = 1'b0; l_rready = 1'b0;
        step();
        step();
        #1;
        chk("pre_rst_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("pre_rst_l_rvalid", 32'(l_rvalid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_f_rvalid", 32'(f_rvalid), 32'd0);
        chk("async_l_rvalid", 32'(l_rvalid), 32'd0);
        chk("async_f_rdata",  f_rdata, 32'd0);
        chk("async_l_rdata",  l_rdata, 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_f_gnt", 32'(f_gnt), 32'd1);
        chk("post_rst_l_gnt", 32'(l_gnt), 32'd0);

        // Randomized traffic; requesters hold req/addr until granted
        pf = 1'b1; pl = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (!f_req || pf) begin f_req = ($urandom_range(0, 3) != 0); f_addr = AW'($urandom); end
            if (!l_req || pl) begin l_req = ($urandom_range(0, 2) != 0); l_addr = AW'($urandom); end
            f_rready = ($urandom_range(0, 3) != 0);
            l_rready = ($urandom_range(0, 2) != 0);
            #1;
            pf = f_gnt; pl = l_gnt;
        end

`ifdef IMEM_ARB_STATS_EN
        f_req = 1'b0; l_req = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        f_req = 1'b1; l_req = 1'b1; f_rready = 1'b1; l_rready = 1'b1;
        repeat (10) step();
        chk("stats_conflict", 32'(conflict_cnt), 32'd10);
        chk("stats_forced",   32'(forced_cnt),   32'd2);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational-read instruction memory between two read requesters: the fetch stage (port F) and the constant/literal load path (port L).
- Fetch has fixed priority. A starvation counter forces an L grant after L has waited STARVE_LIMIT consecutive cycles.
- Each port gets a one-deep registered response buffer with a valid/ready handshake.
- Sits between the fetch/execute stages and the instruction memory.

Parameters:
- ADDR_BIT_WIDTH, 11, word-address width; matches the instruction memory.
- DATA_BIT_WIDTH, 32, instruction word width.
- STARVE_LIMIT, 4, consecutive denied-L cycles before L is forced; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request
- f_addr  in  ADDR_BIT_WIDTH  fetch word address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch response valid
- f_rdata  out  DATA_BIT_WIDTH  fetch response word
- f_rready  in  1  fetch consumer accepts the response
- l_req  in  1  load read request
- l_addr  in  ADDR_BIT_WIDTH  load word address
- l_gnt  out  1  load request accepted this cycle (combinational)
- l_rvalid  out  1  load response valid
- l_rdata  out  DATA_BIT_WIDTH  load response word
- l_rready  in  1  load consumer accepts the response
- mem_addr  out  ADDR_BIT_WIDTH  address to the instruction memory
- mem_data  in  DATA_BIT_WIDTH  combinational read data from the instruction memory

Behaviour:
- Reset (async, reset_n low):
  - f_rvalid = 0, l_rvalid = 0.
  - f_rdata and l_rdata = 0.
  - Starvation counter = 0.
  - Takes effect immediately and mid-transaction. Pending responses are discarded and requests are not remembered.
- Port eligibility: a port is eligible when req = 1 AND (rvalid = 0 OR rready = 1). Its buffer is free, or is drained this same cycle.
- Grant decision (combinational, at most one grant per cycle):
  - force_l = (starve_cnt >= STARVE_LIMIT) AND L eligible.
  - force_l = 1: l_gnt = 1, f_gnt = 0.
  - Otherwise F eligible: f_gnt = 1.
  - Otherwise L eligible: l_gnt = 1.
  - Otherwise no grant.
- mem_addr:
  - l_addr when l_gnt = 1, else f_addr.
  - Fetch is the default, so the address is stable when idle.
- Capture: on a clock edge with x_gnt = 1, x_rdata <= mem_data and x_rvalid <= 1. Latency is 1 cycle from grant to rvalid.
- Drain: on an edge with x_rvalid = 1, x_rready = 1 and no new grant, x_rvalid <= 0 and x_rdata holds its value.
- Simultaneous drain and grant on one port: the new data is captured and rvalid stays 1. Back-to-back throughput is 1 word/cycle per port.
- Non-granted port: rvalid and rdata are unchanged. The held response is stable until it is accepted.
- Starvation counter (4 bits):
  - Cleared when l_gnt = 1 or l_req = 0.
  - Incremented, saturating at 15, when l_req = 1, L eligible and l_gnt = 0.
  - Held when l_req = 1 but L is ineligible because its own buffer is full. Back-pressure is not starvation.
- Requesters hold req/addr stable until gnt. The arbiter does not latch addresses of ungranted requests.
- Address range: the full ADDR_BIT_WIDTH range is valid. No wrap or bounds checking.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs conflict_cnt[15:0] and forced_cnt[15:0], both reset to 0.
  - conflict_cnt increments, saturating at 16'hFFFF, on every cycle where F and L are both eligible.
  - forced_cnt increments, saturating, on every cycle where force_l = 1.
- Undefined: the ports and logic are absent. Arbitration behaviour is identical either way.

Test Plan:
- Single fetch:
  - Stimulus: reset, then f_req = 1, f_addr = 0x010 with memory word 0x10 = 0xDEADBEEF, f_rready = 1.
  - Response: f_gnt = 1 the same cycle; next cycle f_rvalid = 1 and f_rdata = 0xDEADBEEF; l_gnt stays 0.
- Conflict:
  - Stimulus: f_req = 1 and l_req = 1 continuously, both rready = 1, STARVE_LIMIT = 4.
  - Response: grants follow F,F,F,F,L,F,F,F,F,L…; mem_addr = l_addr exactly in the L cycles.
- Back-pressure:
  - Stimulus: f_rready = 0 after the first response, f_req held at 1.
  - Response: f_gnt = 0 and f_rdata stable for 5 cycles. Raising f_rready gives f_gnt = 1 the same cycle, and new data the next cycle with no bubble.
- Load buffer full:
  - Stimulus: l_rvalid = 1, l_rready = 0, l_req = 1, f_req = 1 for 10 cycles.
  - Response: the starvation counter holds; no forced L grant; F is granted every cycle.
- Reset mid-operation:
  - Stimulus: drive reset_n low asynchronously while f_rvalid = 1 and l_rvalid = 1.
  - Response: both rvalid = 0 and rdata = 0 immediately, before the next clk edge; after release, the first grant goes to F.
- IMEM_ARB_STATS_EN:
  - Stimulus: 10 cycles of dual eligible requests with STARVE_LIMIT = 4.
  - Response: conflict_cnt = 10, forced_cnt = 2.
